// File: rtl/fb_write_sched_if.sv
// Write-port bundle between the framebuffer scheduler and its pixel producers / RAM.
// The master modport is the producer/RAM side; the slave modport is the scheduler.
interface fb_write_sched_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  clear_req;
    logic                  clear_value;
    logic                  clear_busy;
    logic                  req0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic                  pixel0;
    logic                  gnt0;
    logic                  req1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic                  pixel1;
    logic                  gnt1;
    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  pixel;
    logic                  err;

    modport slave (
        input  clear_req, clear_value, req0, addr0, pixel0, req1, addr1, pixel1,
        output clear_busy, gnt0, gnt1, we, write_addr, pixel, err
    );

    modport master (
        output clear_req, clear_value, req0, addr0, pixel0, req1, addr1, pixel1,
        input  clear_busy, gnt0, gnt1, we, write_addr, pixel, err
    );
endinterface

// File: rtl/fb_write_sched.sv
// Framebuffer write-port scheduler: round-robin between two pixel writers, with a
// full-frame clear engine that owns the port for exactly one pass over the frame.
module fb_write_sched #(
    parameter int ADDR_WIDTH = 15,
    parameter int H_RES      = 160,
    parameter int V_RES      = 120
) (
    input logic             clk_25,
    input logic             reset,
    fb_write_sched_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] FB_DEPTH = ADDR_WIDTH'(H_RES * V_RES);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(H_RES * V_RES - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t                state_q;
    logic                  rr_ptr_q;
    logic                  clr_val_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  pixel_q;
    logic                  err_q;

    logic                  gnt0_d;
    logic                  gnt1_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic                  wr_pixel_d;

    // Grants are combinational so a requester is released in the cycle it is served.
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (!reset && state_q == ARB) begin
            if (bus.req0 && (!bus.req1 || !rr_ptr_q)) begin
                gnt0_d = 1'b1;
            end else if (bus.req1) begin
                gnt1_d = 1'b1;
            end
        end
        wr_addr_d  = gnt1_d ? bus.addr1  : bus.addr0;
        wr_pixel_d = gnt1_d ? bus.pixel1 : bus.pixel0;
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state_q   <= ARB;
            rr_ptr_q  <= 1'b0;
            clr_val_q <= 1'b0;
            clr_cnt_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            pixel_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (gnt0_d || gnt1_d) begin
                        // The loser of this grant wins the next tie.
                        rr_ptr_q <= gnt0_d;
                        if (wr_addr_d >= FB_DEPTH) begin
                            err_q <= 1'b1;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= wr_addr_d;
                            pixel_q <= wr_pixel_d;
                        end
                    end
                    if (bus.clear_req) begin
                        state_q   <= CLEAR;
                        clr_val_q <= bus.clear_value;
                        clr_cnt_q <= '0;
                    end
                end
                CLEAR: begin
                    we_q    <= 1'b1;
                    addr_q  <= clr_cnt_q;
                    pixel_q <= clr_val_q;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q   <= ARB;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ONE;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign bus.gnt0       = gnt0_d;
    assign bus.gnt1       = gnt1_d;
    assign bus.clear_busy = (state_q == CLEAR);
    assign bus.we         = we_q;
    assign bus.write_addr = addr_q;
    assign bus.pixel      = pixel_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_fb_write_sched.sv
// Scoreboard bench for fb_write_sched: a driver models grants and the clear pass,
// queues expected writes, and a monitor pops them as the write port presents them.
module tb_fb_write_sched;
    localparam int AW    = 15;
    localparam int DEPTH = 160 * 120;

    logic clk_25 = 1'b0;
    logic reset  = 1'b1;
    always #20 clk_25 = ~clk_25;

    fb_write_sched_if #(.ADDR_WIDTH(AW)) bus ();

    fb_write_sched #(.ADDR_WIDTH(AW), .H_RES(160), .V_RES(120)) dut (
        .clk_25(clk_25),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int tag;
        int addr;
        bit pix;
        bit err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    bit   pend0 = 0, pend1 = 0;
    int   a0 = 0, a1 = 0;
    bit   p0 = 0, p1 = 0;
    int   clear_left = 0;
    bit   next_tie = 0;
    bit   chk_zero = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int rand_addr();
        int r = int'($urandom % 8);
        if (r == 0) return DEPTH + int'($urandom % (32768 - DEPTH));
        if (r == 1) return DEPTH - 1;
        return int'($urandom % DEPTH);
    endfunction

    initial begin
        bus.clear_req   = 1'b0;
        bus.clear_value = 1'b0;
        bus.req0        = 1'b0;
        bus.addr0       = '0;
        bus.pixel0      = 1'b0;
        bus.req1        = 1'b0;
        bus.addr1       = '0;
        bus.pixel1      = 1'b0;
    end

    // Monitor: every presented write/err must match the oldest expected entry.
    always @(posedge clk_25) begin
        cyc++;
        #1;
        if (bus.we || bus.err) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write @cyc %0d: got we=%0d err=%0d addr=%0d, required no write",
                         cyc, bus.we, bus.err, bus.write_addr);
            end else begin
                mon_e = sbq.pop_front();
                chk("write_cycle", cyc, mon_e.tag);
                chk("we", int'(bus.we), int'(!mon_e.err));
                chk("err", int'(bus.err), int'(mon_e.err));
                if (!mon_e.err) begin
                    chk("write_addr", int'(bus.write_addr), mon_e.addr);
                    chk("pixel", int'(bus.pixel), int'(mon_e.pix));
                end
            end
        end else if (sbq.size() > 0 && sbq[0].tag <= cyc) begin
            mon_e = sbq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_write @cyc %0d: got no write, required addr=%0d err=%0d",
                     cyc, mon_e.addr, mon_e.err);
        end
    end

    // One clock of stimulus plus the reference model's view of that clock.
    task automatic step(input bit rst_v, input bit clr_v, input bit clr_val_v);
        bit busy_m;
        bit g0, g1;
        int win;
        @(negedge clk_25);
        reset           = rst_v;
        bus.clear_req   = clr_v;
        bus.clear_value = clr_val_v;
        bus.req0        = pend0;
        bus.addr0       = a0[AW-1:0];
        bus.pixel0      = p0;
        bus.req1        = pend1;
        bus.addr1       = a1[AW-1:0];
        bus.pixel1      = p1;
        #1;
        if (chk_zero) begin
            chk("rst_we", int'(bus.we), 0);
            chk("rst_write_addr", int'(bus.write_addr), 0);
            chk("rst_pixel", int'(bus.pixel), 0);
            chk("rst_err", int'(bus.err), 0);
            chk_zero = 0;
        end
        busy_m = (clear_left > 0);
        win = -1;
        if (!rst_v && !busy_m) begin
            if (pend0 && pend1) win = int'(next_tie);
            else if (pend0) win = 0;
            else if (pend1) win = 1;
        end
        g0 = (win == 0);
        g1 = (win == 1);
        chk("gnt0", int'(bus.gnt0), int'(g0));
        chk("gnt1", int'(bus.gnt1), int'(g1));
        chk("clear_busy", int'(bus.clear_busy), int'(busy_m));
        if (win >= 0) begin
            int wa = (win == 0) ? a0 : a1;
            sbq.push_back('{tag: cyc + 1, addr: wa, pix: (win == 0) ? p0 : p1, err: (wa >= DEPTH)});
            next_tie = (win == 0);
            if (win == 0) pend0 = 0; else pend1 = 0;
        end
        if (rst_v) begin
            while (sbq.size() > 0 && sbq[$].tag > cyc) void'(sbq.pop_back());
            clear_left = 0;
            next_tie   = 0;
        end else if (busy_m) begin
            clear_left--;
        end else if (clr_v) begin
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++)
                sbq.push_back('{tag: cyc + 2 + i, addr: i, pix: clr_val_v, err: 1'b0});
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requesters asserting, then round-robin 0,1,0,1.
        pend0 = 1; a0 = 11; p0 = 1;
        pend1 = 1; a1 = 22; p1 = 0;
        step(1, 0, 0);
        step(1, 0, 0);
        chk_zero = 1;
        for (int i = 0; i < 4; i++) begin
            if (!pend0) begin pend0 = 1; a0 = 1000 + i; p0 = i[0]; end
            if (!pend1) begin pend1 = 1; a1 = 2000 + i; p1 = !i[0]; end
            step(0, 0, 0);
        end
        pend0 = 0; pend1 = 0;
        step(0, 0, 0);
        step(0, 0, 0);

        // Single requester.
        pend0 = 1; a0 = 100; p0 = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);

        // Range boundary on requester 1.
        pend1 = 1; a1 = DEPTH; p1 = 1;
        step(0, 0, 0);
        pend1 = 1; a1 = DEPTH - 1; p1 = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);

        // Full clear with a pending requester and a mid-clear re-pulse.
        pend0 = 1; a0 = 7; p0 = 0;
        step(0, 1, 1);
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (!pend0) begin pend0 = 1; a0 = 300 + (i % 50); p0 = 1; end
            step(0, (i == 5000), 1'b0);
        end
        pend0 = 0;
        step(0, 0, 0);

        // Clear aborted by reset while clr_cnt is 500.
        step(0, 1, 0);
        for (int i = 0; i < 500; i++) step(0, 0, 0);
        step(1, 0, 0);
        chk_zero = 1;
        step(0, 0, 0);
        step(0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if (!pend0 && ($urandom % 2 == 0)) begin pend0 = 1; a0 = rand_addr(); p0 = 1'($urandom % 2); end
            if (!pend1 && ($urandom % 2 == 0)) begin pend1 = 1; a1 = rand_addr(); p1 = 1'($urandom % 2); end
            step(0, 0, 0);
        end

        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("queue_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
